// File: rtl/encoder_pkg.sv
// Shared types and quadrature decode helper for the multi-channel encoder front end.
package encoder_pkg;

  localparam int unsigned STEPS_2X = 2;
  localparam int unsigned STEPS_4X = 4;

  typedef logic [1:0] ab_t;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  typedef struct packed {
    dir_t dir;
    logic illegal;
  } quad_t;

  // ab = {a,b}; up runs 00->10->11->01->00, down is the reverse.
  function automatic quad_t quad_dir(input ab_t prev, input ab_t cur, input int unsigned steps);
    quad_t q;
    q.dir     = DIR_HOLD;
    q.illegal = 1'b0;
    if ((prev ^ cur) == 2'b11) begin
      q.illegal = 1'b1;
    end else begin
      case ({prev, cur})
        4'b00_10, 4'b11_01: q.dir = DIR_UP;
        4'b00_01, 4'b11_10: q.dir = DIR_DOWN;
        4'b10_11, 4'b01_00: if (steps == STEPS_4X) q.dir = DIR_UP;
        4'b01_11, 4'b10_00: if (steps == STEPS_4X) q.dir = DIR_DOWN;
        default: ;
      endcase
    end
    return q;
  endfunction

endpackage

// File: rtl/encoder_multi_channel.sv
// One encoder channel: 2-FF sync, debounce, quadrature decode and value register.
// Optional sticky illegal-transition flag built only when ENCODER_ERR_EN is defined.
module encoder_channel
  import encoder_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned INCREMENT = 1,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned STEPS     = STEPS_2X,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             err
);

  localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INCREMENT);

  ab_t sync1, sync2, acc, accepted;
  quad_t q;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] step_val, next_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_nodb
      assign accepted = sync2;
    end else begin : g_db
      localparam int unsigned CW = $clog2(DEBOUNCE + 1);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
      ab_t cand;
      logic [CW-1:0] cnt;

      // cnt holds how many consecutive cycles sync2 has matched cand, saturating at DEBOUNCE
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cand <= '0;
          cnt  <= '0;
        end else if (sync2 != cand) begin
          cand <= sync2;
          cnt  <= CW'(1);
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CW'(1);
        end
      end

      assign accepted = (sync2 == cand && cnt == CNT_MAX) ? cand : acc;
    end
  endgenerate

  assign q = quad_dir(acc, accepted, STEPS);

  always_comb begin
    sum      = {1'b0, value} + INC_EXT;
    diff     = {1'b0, value} - INC_EXT;
    step_val = value;
    case (q.dir)
      DIR_UP:   step_val = (SATURATE != 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
      DIR_DOWN: step_val = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default:  step_val = value;
    endcase
    next_val = clr ? '0 : step_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      value   <= '0;
      changed <= 1'b0;
    end else begin
      acc     <= accepted;
      value   <= next_val;
      changed <= (next_val != value);
    end
  end

`ifdef ENCODER_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       err <= 1'b0;
    else if (q.illegal) err <= 1'b1;
    else if (clr)       err <= 1'b0;
  end
`else
  logic unused_illegal;
  assign unused_illegal = q.illegal;
  assign err = 1'b0;
`endif

endmodule

// File: rtl/encoder_multi.sv
// N-channel quadrature encoder front end; ENCODER_ERR_EN enables the sticky err flags.
module encoder_multi
  import encoder_pkg::*;
#(
  parameter int unsigned CHANNELS  = 3,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned INCREMENT = 1,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned STEPS     = STEPS_2X,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS-1:0]       err
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      encoder_channel #(
        .WIDTH    (WIDTH),
        .INCREMENT(INCREMENT),
        .DEBOUNCE (DEBOUNCE),
        .STEPS    (STEPS),
        .SATURATE (SATURATE)
      ) u_ch (
        .clk    (clk),
        .reset_n(reset_n),
        .a      (a[i]),
        .b      (b[i]),
        .clr    (clr[i]),
        .value  (value[i*WIDTH +: WIDTH]),
        .changed(changed[i]),
        .err    (err[i])
      );
    end
  endgenerate

endmodule
